sha256_msg_padder: RTL

Streaming SHA-256 message padder that sits directly upstream of the hashing cores in the SDRAM-based SHA-2 system. It accepts a message as a stream of big-endian 32-bit words, for example fetched from SDRAM by the DMA front end. It emits complete 512-bit blocks as sixteen 32-bit words each, with the FIPS 180-4 padding already applied: the 0x80 marker, zero fill, and the 64-bit big-endian bit length. Cores downstream consume only whole, pre-padded blocks.

---
 rtl/sha256_msg_padder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/sha256_msg_padder.sv
// -----------------------------------------------------------------------------
// sha256_msg_padder
//
// Streaming SHA-256 message padder. Takes a message as big-endian 32-bit words
// and emits whole 512-bit blocks as sixteen 32-bit words. The output already
// carries the 0x80 marker, the zero fill and the 64-bit big-endian bit length.
//
// Ports
//   sys_clk_clk    : single clock, rising edge
//   reset_reset_n  : synchronous, active-low reset
//   in_valid/in_ready/in_data/in_last/in_bytes : message word stream
//                    (in_bytes = valid bytes of the last word, 0 means 4)
//   out_valid/out_ready/out_data : padded block word stream
//   out_first      : word index 0 of a block
//   out_blk_last   : word index 15 of a block
//   out_msg_end    : word index 15 of the final block of a message
// -----------------------------------------------------------------------------
module sha256_msg_padder #(
    parameter int CNT_W = 32
) (
    input  logic        sys_clk_clk,
    input  logic        reset_reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [1:0]  in_bytes,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_first,
    output logic        out_blk_last,
    output logic        out_msg_end
);

    typedef enum logic [2:0] {
        ST_DATA,
        ST_MARK,
        ST_ZERO,
        ST_LEN_HI,
        ST_LEN_LO
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       widx_q, widx_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             out_first_q, out_first_d;
    logic             out_blk_last_q, out_blk_last_d;
    logic             out_msg_end_q, out_msg_end_d;

    logic             advance;
    logic             in_fire;
    logic [2:0]       last_bytes;
    logic [2:0]       cnt_inc;
    logic [31:0]      tail_word;
    logic [63:0]      bit_len;
    state_t           after_mark;
    logic             emit;
    logic [31:0]      emit_data;
    logic             emit_end;

    // The output register may be reloaded whenever it is empty or being drained.
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = reset_reset_n && (state_q == ST_DATA) && advance;
    assign in_fire  = in_valid && in_ready;

    assign last_bytes = (in_bytes == 2'd0) ? 3'd4 : {1'b0, in_bytes};
    assign cnt_inc    = in_last ? last_bytes : 3'd4;
    assign bit_len    = 64'(byte_cnt_q) << 3;

    // Where to go after the word carrying 0x80 has been emitted at widx_q.
    // Only index 13 leaves no room for zero fill before the length words;
    // indices 14/15 spill the zero fill into the next block.
    assign after_mark = (widx_q == 4'd13) ? ST_LEN_HI : ST_ZERO;

    // Final partial word: keep the valid bytes, drop in 0x80, zero the rest.
    always_comb begin
        tail_word = in_data;
        case (in_bytes)
            2'd1:    tail_word = {in_data[31:24], 8'h80, 16'h0000};
            2'd2:    tail_word = {in_data[31:16], 8'h80, 8'h00};
            2'd3:    tail_word = {in_data[31:8], 8'h80};
            default: tail_word = in_data;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        widx_d         = widx_q;
        byte_cnt_d     = byte_cnt_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_first_d    = out_first_q;
        out_blk_last_d = out_blk_last_q;
        out_msg_end_d  = out_msg_end_q;
        emit           = 1'b0;
        emit_data      = 32'h0000_0000;
        emit_end       = 1'b0;

        // Everything freezes while a word sits stalled in the output register.
        if (advance) begin
            case (state_q)
                ST_DATA: begin
                    if (in_fire) begin
                        emit       = 1'b1;
                        emit_data  = in_data;
                        byte_cnt_d = byte_cnt_q + CNT_W'(cnt_inc);
                        if (in_last) begin
                            if (in_bytes == 2'd0) begin
                                // Full last word: marker needs a word of its own.
                                state_d = ST_MARK;
                            end else begin
                                emit_data = tail_word;
                                state_d   = after_mark;
                            end
                        end
                    end
                end
                ST_MARK: begin
                    emit      = 1'b1;
                    emit_data = 32'h8000_0000;
                    state_d   = after_mark;
                end
                ST_ZERO: begin
                    emit = 1'b1;
                    if (widx_q == 4'd13) begin
                        state_d = ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    emit      = 1'b1;
                    emit_data = bit_len[63:32];
                    state_d   = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    emit       = 1'b1;
                    emit_data  = bit_len[31:0];
                    emit_end   = 1'b1;
                    byte_cnt_d = '0;
                    state_d    = ST_DATA;
                end
                default: begin
                    state_d = ST_DATA;
                end
            endcase

            out_valid_d = emit;
            if (emit) begin
                out_data_d     = emit_data;
                out_first_d    = (widx_q == 4'd0);
                out_blk_last_d = (widx_q == 4'd15);
                out_msg_end_d  = emit_end;
                widx_d         = widx_q + 4'd1;
            end
        end
    end

    always_ff @(posedge sys_clk_clk) begin
        if (!reset_reset_n) begin
            state_q        <= ST_DATA;
            widx_q         <= 4'd0;
            byte_cnt_q     <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= 32'h0000_0000;
            out_first_q    <= 1'b0;
            out_blk_last_q <= 1'b0;
            out_msg_end_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            widx_q         <= widx_d;
            byte_cnt_q     <= byte_cnt_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_first_q    <= out_first_d;
            out_blk_last_q <= out_blk_last_d;
            out_msg_end_q  <= out_msg_end_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_first    = out_first_q;
    assign out_blk_last = out_blk_last_q;
    assign out_msg_end  = out_msg_end_q;

endmodule
